// File: rtl/deu_pkg.sv
// rtl/deu_pkg.sv - shared types and default geometry for the decode instruction buffer
`ifndef LA64_PC_WIDTH
`define LA64_PC_WIDTH 64
`endif

package deu_pkg;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_FETCH_W = 2;
    localparam int DEF_DEC_W   = 2;
    localparam int DEF_INST_W  = 32;

    // pc bit 0 is always zero, so entries keep bits [PC_WIDTH-1:1]
    localparam int PC_W = `LA64_PC_WIDTH - 1;

    localparam int DEF_PTR_W = $clog2(DEF_DEPTH);
    localparam int DEF_CNT_W = $clog2(DEF_DEPTH + 1);

    typedef struct packed {
        logic [`LA64_PC_WIDTH-1:1] pc;
        logic [DEF_INST_W-1:0]     inst;
    } ib_entry_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/deu_ibuf_ram.sv
// rtl/deu_ibuf_ram.sv - entry array, FETCH_W write ports, DEC_W asynchronous read ports
module deu_ibuf_ram
    import deu_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int FETCH_W = DEF_FETCH_W,
    parameter int DEC_W   = DEF_DEC_W,
    parameter int INST_W  = DEF_INST_W,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we    [FETCH_W],
    input  logic [PTR_W-1:0]  waddr [FETCH_W],
    input  logic [PC_W-1:0]   wpc   [FETCH_W],
    input  logic [INST_W-1:0] winst [FETCH_W],
    input  logic [PTR_W-1:0]  raddr [DEC_W],
    output logic [PC_W-1:0]   rpc   [DEC_W],
    output logic [INST_W-1:0] rinst [DEC_W]
);
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ram_entry_t;

    ram_entry_t mem [DEPTH];

    // write addresses within one cycle are always distinct (consecutive mod DEPTH)
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (we[i]) begin
                mem[waddr[i]] <= '{pc: wpc[i], inst: winst[i]};
            end
        end
    end

    always_comb begin
        for (int j = 0; j < DEC_W; j++) begin
            rpc[j]   = mem[raddr[j]].pc;
            rinst[j] = mem[raddr[j]].inst;
        end
    end
endmodule

// File: rtl/deu_ibuf.sv
// rtl/deu_ibuf.sv - pointer-based decode instruction buffer; optional same-cycle bypass via DEU_IBUF_BYPASS_EN
module deu_ibuf
    import deu_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int FETCH_W = DEF_FETCH_W,
    parameter int DEC_W   = DEF_DEC_W,
    parameter int INST_W  = DEF_INST_W,
    localparam int FC_W   = $clog2(FETCH_W + 1),
    localparam int DC_W   = $clog2(DEC_W + 1),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      ifu_valid,
    input  logic [FC_W-1:0]           ifu_cnt,
    input  logic [FETCH_W*PC_W-1:0]   ifu_pc,
    input  logic [FETCH_W*INST_W-1:0] ifu_inst,
    output logic                      ifu_ready,
    output logic [DEC_W-1:0]          dec_valid,
    output logic [DEC_W*PC_W-1:0]     dec_pc,
    output logic [DEC_W*INST_W-1:0]   dec_inst,
    input  logic [DC_W-1:0]           dec_take,
    output logic [CNT_W-1:0]          ib_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic [CNT_W-1:0] n_in, n_take, n_wr, n_out, skip, avail, avail_arr, take_w;

    logic              we    [FETCH_W];
    logic [PTR_W-1:0]  waddr [FETCH_W];
    logic [PC_W-1:0]   wpc   [FETCH_W];
    logic [INST_W-1:0] winst [FETCH_W];
    logic [PTR_W-1:0]  raddr [DEC_W];
    logic [PC_W-1:0]   rpc   [DEC_W];
    logic [INST_W-1:0] rinst [DEC_W];

    assign ifu_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
    assign ib_cnt    = count;
    assign accept    = ifu_valid & ifu_ready & ~flush;
    assign n_in      = accept ? CNT_W'(ifu_cnt) : '0;
    assign avail_arr = (count > CNT_W'(DEC_W)) ? CNT_W'(DEC_W) : count;
    assign take_w    = CNT_W'(dec_take);
    assign n_take    = (take_w > avail) ? avail : take_w;
    assign n_wr      = n_in - skip;

`ifdef DEU_IBUF_BYPASS_EN
    logic             byp_act;
    logic [CNT_W-1:0] byp_n;

    assign byp_act = accept && (count == '0);
    assign byp_n   = (n_in > CNT_W'(DEC_W)) ? CNT_W'(DEC_W) : n_in;
    assign avail   = byp_act ? byp_n : avail_arr;
    // bypassed slots that decode consumes never reach the array
    assign skip    = byp_act ? n_take : '0;
    assign n_out   = byp_act ? '0 : n_take;

    always_comb begin
        dec_valid = '0;
        dec_pc    = '0;
        dec_inst  = '0;
        for (int j = 0; j < DEC_W; j++) begin
            if (byp_act) begin
                dec_valid[j] = CNT_W'(j) < byp_n;
                if (j < FETCH_W) begin
                    dec_pc[j*PC_W +: PC_W]       = ifu_pc[j*PC_W +: PC_W];
                    dec_inst[j*INST_W +: INST_W] = ifu_inst[j*INST_W +: INST_W];
                end
            end else begin
                dec_valid[j]                 = CNT_W'(j) < count;
                dec_pc[j*PC_W +: PC_W]       = rpc[j];
                dec_inst[j*INST_W +: INST_W] = rinst[j];
            end
        end
    end
`else
    assign avail = avail_arr;
    assign skip  = '0;
    assign n_out = n_take;

    always_comb begin
        dec_valid = '0;
        dec_pc    = '0;
        dec_inst  = '0;
        for (int j = 0; j < DEC_W; j++) begin
            dec_valid[j]                 = CNT_W'(j) < count;
            dec_pc[j*PC_W +: PC_W]       = rpc[j];
            dec_inst[j*INST_W +: INST_W] = rinst[j];
        end
    end
`endif

    // write port i carries fetch slot i+skip to entry tail+i
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            we[i]    = (CNT_W'(i) + skip) < n_in;
            waddr[i] = tail + PTR_W'(i);
            wpc[i]   = '0;
            winst[i] = '0;
            for (int k = 0; k < FETCH_W; k++) begin
                if (CNT_W'(k) == CNT_W'(i) + skip) begin
                    wpc[i]   = ifu_pc[k*PC_W +: PC_W];
                    winst[i] = ifu_inst[k*INST_W +: INST_W];
                end
            end
        end
        for (int j = 0; j < DEC_W; j++) begin
            raddr[j] = head + PTR_W'(j);
        end
    end

    deu_ibuf_ram #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .DEC_W   (DEC_W),
        .INST_W  (INST_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wpc   (wpc),
        .winst (winst),
        .raddr (raddr),
        .rpc   (rpc),
        .rinst (rinst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_out);
            tail  <= tail + PTR_W'(n_wr);
            count <= count + n_wr - n_out;
        end
    end

    a_take_le_valid : assert property (@(posedge clk) disable iff (!rst_n)
        flush || (take_w <= avail));
endmodule
